// File: rtl/router_input_arbiter_pkg.sv
// Shared types and sizes for the router ingress arbiter (router_input_arbiter and rr_pick).
package router_pkg;
  localparam int NUM_SRC   = 4;
  localparam int ADDR_W    = 2;
  localparam int SRC_IDX_W = 2;
  localparam int STAT_W    = 16;

  typedef enum logic {IDLE, GRANT} arb_state_t;
endpackage

// File: rtl/router_input_arbiter_rr_pick.sv
// Combinational 4-way round-robin priority encoder: first requester at or after ptr wins.
module rr_pick
  import router_pkg::*;
(
  input  logic [NUM_SRC-1:0]   req,
  input  logic [SRC_IDX_W-1:0] ptr,
  output logic [NUM_SRC-1:0]   gnt,
  output logic [SRC_IDX_W-1:0] idx,
  output logic                 any
);
  always_comb begin
    logic                 v_found;
    logic [SRC_IDX_W-1:0] v_cand;
    v_found = 1'b0;
    v_cand  = '0;
    idx     = '0;
    any     = |req;
    for (int k = 0; k < NUM_SRC; k++) begin
      v_cand = ptr + SRC_IDX_W'(k);
      if (!v_found && req[v_cand]) begin
        v_found = 1'b1;
        idx     = v_cand;
      end
    end
    gnt = any ? (NUM_SRC'(1) << idx) : '0;
  end
endmodule

// File: rtl/router_input_arbiter.sv
// Round-robin, burst-holding arbiter sharing the router ingress among 4 sources.
// Optional per-source beat counters are built when ROUTER_ARB_STATS_EN is defined.
module router_input_arbiter
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC-1:0]            s_valid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_data,
  input  logic [NUM_SRC*ADDR_W-1:0]     s_addr,
  output logic [NUM_SRC-1:0]            s_ready,
  output logic [DATA_WIDTH-1:0]         r_din,
  output logic [ADDR_W-1:0]             r_addr,
  output logic                          r_valid,
  input  logic                          r_ready,
  output logic [NUM_SRC-1:0]            grant,
  output logic                          busy
`ifdef ROUTER_ARB_STATS_EN
  ,
  input  logic                          stat_clr,
  output logic [NUM_SRC*STAT_W-1:0]     stat_beats
`endif
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t           r_state;
  logic [SRC_IDX_W-1:0] r_rr_ptr;
  logic [SRC_IDX_W-1:0] r_idx;
  logic [CNT_W-1:0]     r_beat_cnt;
  logic [NUM_SRC-1:0]   r_grant;
  logic                 r_busy;

  logic [NUM_SRC-1:0]    w_pick_gnt;
  logic [SRC_IDX_W-1:0]  w_pick_idx;
  logic                  w_any;
  logic                  w_own_valid;
  logic [DATA_WIDTH-1:0] w_own_data;
  logic [ADDR_W-1:0]     w_own_addr;
  logic                  w_accept;
  logic                  w_release;

  rr_pick u_rr_pick (
    .req (s_valid),
    .ptr (r_rr_ptr),
    .gnt (w_pick_gnt),
    .idx (w_pick_idx),
    .any (w_any)
  );

  assign w_own_valid = s_valid[r_idx];
  assign w_own_data  = s_data[r_idx*DATA_WIDTH +: DATA_WIDTH];
  assign w_own_addr  = s_addr[r_idx*ADDR_W +: ADDR_W];
  assign w_accept    = (r_state == GRANT) && w_own_valid && r_ready;
  // A stalled beat (valid && !ready) never releases: neither term below can be true.
  assign w_release   = (w_accept && (r_beat_cnt == CNT_W'(MAX_BURST - 1))) || !w_own_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_idx      <= '0;
      r_beat_cnt <= '0;
      r_grant    <= '0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state <= GRANT;
            r_grant <= w_pick_gnt;
            r_idx   <= w_pick_idx;
            r_busy  <= 1'b1;
          end
        end
        GRANT: begin
          if (w_release) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_busy     <= 1'b0;
            r_rr_ptr   <= r_idx + SRC_IDX_W'(1);
            r_beat_cnt <= '0;
          end else if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    r_valid = 1'b0;
    r_din   = '0;
    r_addr  = '0;
    s_ready = '0;
    if (r_state == GRANT) begin
      r_valid        = w_own_valid;
      r_din          = w_own_data;
      r_addr         = w_own_addr;
      s_ready[r_idx] = r_ready;
    end
  end

  assign grant = r_grant;
  assign busy  = r_busy;

  a_src_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == GRANT && w_own_valid && !r_ready) |=> ($stable(w_own_data) && $stable(w_own_addr)));

`ifdef ROUTER_ARB_STATS_EN
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_stat
    logic [STAT_W-1:0] r_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        r_cnt <= '0;
      else if (stat_clr)
        r_cnt <= '0;
      else if (w_accept && (r_idx == SRC_IDX_W'(gi)) && (r_cnt != '1))
        r_cnt <= r_cnt + STAT_W'(1);
    end
    assign stat_beats[gi*STAT_W +: STAT_W] = r_cnt;
  end
`endif
endmodule

// File: tb/tb_router_input_arbiter.sv
// Directed bench for router_input_arbiter: a cycle table plus hand-written multi-cycle sequences.
module tb_router_input_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  s_valid = '0, s_valid1 = '0;
  logic [31:0] s_data = 32'hA3A2A1A0;
  logic [7:0]  s_addr = 8'h93;
  logic [3:0]  s_ready, s_ready1;
  logic [7:0]  r_din, r_din1;
  logic [1:0]  r_addr, r_addr1;
  logic        r_valid, r_valid1;
  logic        r_ready = 1'b0, r_ready1 = 1'b0;
  logic [3:0]  grant, grant1;
  logic        busy, busy1;
`ifdef ROUTER_ARB_STATS_EN
  logic        stat_clr = 1'b0;
  logic [63:0] stat_beats, stat_beats1;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  router_input_arbiter #(.DATA_WIDTH(8), .MAX_BURST(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_addr(s_addr),
    .s_ready(s_ready), .r_din(r_din), .r_addr(r_addr), .r_valid(r_valid), .r_ready(r_ready),
    .grant(grant), .busy(busy)
`ifdef ROUTER_ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_beats(stat_beats)
`endif
  );

  router_input_arbiter #(.DATA_WIDTH(8), .MAX_BURST(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid1), .s_data(s_data), .s_addr(s_addr),
    .s_ready(s_ready1), .r_din(r_din1), .r_addr(r_addr1), .r_valid(r_valid1), .r_ready(r_ready1),
    .grant(grant1), .busy(busy1)
`ifdef ROUTER_ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_beats(stat_beats1)
`endif
  );

  typedef struct {
    logic [3:0] sv;
    logic       rdy;
    logic [3:0] gnt;
    logic       bsy;
    logic       rv;
    logic [3:0] srdy;
    logic [7:0] din;
    logic [1:0] addr;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Returns on a negedge with rst_n released and all inputs idle.
  task automatic do_reset();
    rst_n    = 1'b0;
    s_valid  = '0;
    s_valid1 = '0;
    r_ready  = 1'b0;
    r_ready1 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{4'b0010, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'h00, 2'd0};
    tbl[1]  = '{4'b0010, 1'b1, 4'b0010, 1'b1, 1'b1, 4'b0010, 8'hA1, 2'd0};
    tbl[2]  = '{4'b0000, 1'b1, 4'b0010, 1'b1, 1'b0, 4'b0010, 8'hA1, 2'd0};
    tbl[3]  = '{4'b1010, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'h00, 2'd0};
    tbl[4]  = '{4'b1010, 1'b1, 4'b1000, 1'b1, 1'b1, 4'b1000, 8'hA3, 2'd2};
    tbl[5]  = '{4'b0010, 1'b1, 4'b1000, 1'b1, 1'b0, 4'b1000, 8'hA3, 2'd2};
    tbl[6]  = '{4'b0011, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'h00, 2'd0};
    tbl[7]  = '{4'b0011, 1'b0, 4'b0001, 1'b1, 1'b1, 4'b0000, 8'hA0, 2'd3};
    tbl[8]  = '{4'b0011, 1'b1, 4'b0001, 1'b1, 1'b1, 4'b0001, 8'hA0, 2'd3};
    tbl[9]  = '{4'b0010, 1'b1, 4'b0001, 1'b1, 1'b0, 4'b0001, 8'hA0, 2'd3};
    tbl[10] = '{4'b0010, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'h00, 2'd0};
    tbl[11] = '{4'b0000, 1'b1, 4'b0010, 1'b1, 1'b0, 4'b0010, 8'hA1, 2'd0};
    tbl[12] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'h00, 2'd0};

    // Reset state, with reset still asserted
    #1;
    check("reset_outputs", {9'd0, grant, busy, r_valid, s_ready, r_din, r_addr}, 32'd0);

    // Table: single-source grants, drop-out release, rr pointer advance, stall
    do_reset();
    for (int i = 0; i < 13; i++) begin
      s_valid = tbl[i].sv;
      r_ready = tbl[i].rdy;
      #1;
      check($sformatf("vec%0d", i), {9'd0, grant, busy, r_valid, s_ready, r_din, r_addr},
            {9'd0, tbl[i].gnt, tbl[i].bsy, tbl[i].rv, tbl[i].srdy, tbl[i].din, tbl[i].addr});
      @(negedge clk);
    end

    // All four sources busy: 4-beat bursts in order 0,1,2,3,0 separated by one idle cycle
    do_reset();
    s_valid = 4'b1111;
    r_ready = 1'b1;
    for (int c = 0; c < 25; c++) begin
      int own;
      own = (c / 5) % 4;
      #1;
      if (c % 5 == 0)
        check($sformatf("rr_all c%0d", c), {20'd0, grant, r_valid, r_din}, 32'd0);
      else
        check($sformatf("rr_all c%0d", c), {20'd0, grant, r_valid, r_din},
              {20'd0, 4'(1 << own), 1'b1, 8'(8'hA0 + own)});
      @(negedge clk);
    end

    // Router stall on src3 for 5 cycles, then 4 accepted beats and release
    do_reset();
    s_valid = 4'b1000;
    r_ready = 1'b0;
    for (int c = 0; c < 11; c++) begin
      logic [31:0] exp;
      r_ready = (c >= 6);
      #1;
      if (c == 0 || c == 10)      exp = 32'd0;
      else if (c <= 5)            exp = {15'd0, 4'b1000, 1'b1, 4'b0000, 8'hA3};
      else                        exp = {15'd0, 4'b1000, 1'b1, 4'b1000, 8'hA3};
      check($sformatf("stall c%0d", c), {15'd0, grant, r_valid, s_ready, r_din}, exp);
      @(negedge clk);
    end

    // Reset in the middle of src2's burst (beat 2), then src0 must win from pointer 0
    do_reset();
    for (int c = 0; c < 8; c++) begin
      s_valid = (c < 5) ? 4'b0010 : 4'b0110;
      r_ready = 1'b1;
      #1;
      if (c == 7) check("midburst_owner", {28'd0, grant}, 32'h4);
      if (c < 7) @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {9'd0, grant, busy, r_valid, s_ready, r_din, r_addr}, 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    s_valid = 4'b0111;
    #1;
    check("post_reset_idle", {27'd0, grant, busy}, 32'd0);
    @(negedge clk);
    #1;
    check("post_reset_grant", {27'd0, grant, busy}, {27'd0, 4'b0001, 1'b1});

    // MAX_BURST=1 instance: src0 and src2 alternate, one beat each
    do_reset();
    s_valid1 = 4'b0101;
    r_ready1 = 1'b1;
    for (int c = 0; c < 8; c++) begin
      logic [3:0] eg;
      eg = (c % 2 == 0) ? 4'b0000 : ((c % 4 == 1) ? 4'b0001 : 4'b0100);
      #1;
      check($sformatf("burst1 c%0d", c), {23'd0, grant1, r_valid1, s_ready1},
            {23'd0, eg, |eg, eg});
      @(negedge clk);
    end
    s_valid1 = '0;

`ifdef ROUTER_ARB_STATS_EN
    // Saturating beat counter on src1, then synchronous clear
    begin
      int beats;
      int cyc;
      beats = 0;
      cyc   = 0;
      do_reset();
      s_valid = 4'b0010;
      r_ready = 1'b1;
      while (beats < 70000 && cyc < 95000) begin
        #1;
        if (r_valid && r_ready) beats++;
        cyc++;
        @(negedge clk);
      end
      check("stats_beats_reached", beats, 70000);
      s_valid = '0;
      #1;
      check("stats_sat", {16'd0, stat_beats[31:16]}, 32'hFFFF);
      check("stats_src0", {16'd0, stat_beats[15:0]}, 32'd0);
      stat_clr = 1'b1;
      @(negedge clk);
      stat_clr = 1'b0;
      #1;
      check("stats_clr", {16'd0, stat_beats[31:16]}, 32'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
